ctrl_seq_v2: RTL
================

// Module: ctrl_seq_v2
// PURPOSE
//  Parametrised multi-cycle control sequencer for the RV32 datapath; next generation of the core control FSM.
//  Adds N prioritised/maskable interrupt lines, byte/half/word data strobes with misalign trap, bus timeout, illegal-opcode flag.
//  Interrupts are taken only at instruction boundaries. Drives PC, register set, ALU muxes and instr/data memory handshakes.
// PARAMETERS
//  NUM_IRQ    4                   number of interrupt request lines (1..16)
//  IRQ_MASK   {NUM_IRQ{1'b1}}     static enable per line; masked lines are never taken
//  TIMEOUT    16                  max cycles waiting for gnt/r_valid before TRAP; 0 disables timeout
//  IRQ_ID_W   $clog2(NUM_IRQ)     width of irq_id (min 1)
// PORTS
//  CLK               in   1         clock, all state on rising edge
//  RES               in   1         reset, synchronous, active-high
//  opcode            in   7         instruction opcode, sampled when instr_r_valid=1 in FWAIT
//  funct3            in   3         instruction funct3, sampled with opcode
//  addr_lo           in   2         ALU result bits [1:0] (data address), used in MEM_REQ
//  instr_req         out  1         instruction fetch request
//  instr_gnt/instr_r_valid in 1     instruction memory grant / read data valid
//  data_req          out  1         data memory request, held until data_gnt
//  data_write_enable out  1         1=store, 0=load
//  data_be           out  4         byte enables
//  data_gnt/data_r_valid in 1       data memory grant / response valid
//  pc_enable, MODE, reg_pc_select   out 1 each  PC update, 0=+4/1=load, 1=Q0 base
//  write_enable      out  1         register set write
//  ALUSrcMux1, ALUSrcMux2, ALUSrcMux1_S, ALUSrcMux2_S out 1 each; ALUOp out 2
//  alu_dm_select, instr_reg_mux     out 1 each  writeback from data memory / hold instr reg
//  irq               in   NUM_IRQ   level interrupt requests; irq_status in 1 (1 = ISR active)
//  irq_ack           out  NUM_IRQ   one-hot acknowledge; irq_id out IRQ_ID_W taken line
//  irq_status_update, irq_context, irq_addr_sel, bckup_reg, mret_sel  out 1 each
//  illegal_instr, bus_err, misalign out 1 each  one-cycle fault pulses
// BEHAVIOUR
//  - RES=1: state<=FETCH, op_q/f3_q/id_q/timer<=0; while RES=1 all outputs 0. After release, FETCH outputs apply.
//  - States FETCH,FWAIT,EXEC,MEM_REQ,MEM_WAIT,WB,IRQ_ENTRY,IRQ_ACK,TRAP. Outputs combinational from state/op_q/inputs; default 0.
//  - FETCH: pend = |(irq & IRQ_MASK) & !irq_status. pend -> IRQ_ENTRY, instr_req=0, id_q<=lowest set index.
//    else instr_req=1; instr_gnt -> FWAIT.
//  - FWAIT: instr_r_valid -> latch opcode/funct3 into op_q/f3_q, EXEC. No irq check mid-instruction.
//  - EXEC/WB decode op_q (ALUOp, muxes, MODE, reg_pc_select identical in both):
//    LUI 0110111: ALUOp=10 Mux2=1 Mux1_S=1 | AUIPC 0010111: 10 Mux1=1 Mux2=1 | OPIMM 0010011: 00 Mux2=1
//    OP 0110011: 01 | JAL 1101111: 11 Mux1=1 Mux2_S=1 MODE=1 | JALR 1100111: 10 Mux1=1 Mux2_S=1 MODE=1 reg_pc_select=1
//    these six: write_enable=1 in EXEC only -> WB.
//    BRANCH 1100011: ALUOp=11 MODE=1 pc_enable=1 -> FETCH.
//    LOAD 0000011: ALUOp=00 Mux2=1 -> MEM_REQ. STORE 0100011: ALUOp=01 Mux2=1 -> MEM_REQ.
//    SYSTEM 1110011 (MRET): pc_enable=MODE=mret_sel=irq_status_update=1, irq_context=0 -> FETCH.
//    other: illegal_instr=1, pc_enable=1 (skip) -> FETCH.
//  - MEM_REQ: LOAD/STORE muxes held; data_write_enable=(op_q==STORE). f3_q[1:0]: 00 be=4'b0001<<addr_lo;
//    01 be=4'b0011<<{addr_lo[1],1'b0}; 10 be=4'b1111. Misaligned (01 & addr_lo[0], 10 & addr_lo!=0, or 11):
//    no data_req, misalign=1 -> TRAP. Else data_req=1 until data_gnt -> MEM_WAIT.
//  - MEM_WAIT: data_req=0, load: instr_reg_mux=1; data_r_valid -> load: write_enable=1 alu_dm_select=1; -> WB.
//  - WB: pc_enable=1 -> FETCH.
//  - IRQ_ENTRY: pc_enable=MODE=bckup_reg=irq_addr_sel=irq_status_update=irq_context=1, irq_id=id_q -> IRQ_ACK.
//  - IRQ_ACK: irq_ack=1<<id_q for exactly 1 cycle, irq_id=id_q -> FETCH.
//  - TRAP: pc_enable=1 (skip faulting instr) -> FETCH. bus_err pulse is asserted on the timeout cycle.
//  - Timeout: timer clears on every state change; increments in FETCH (after instr_req), FWAIT, MEM_REQ, MEM_WAIT.
//    timer==TIMEOUT-1 with no handshake -> bus_err=1, request dropped, next TRAP. A handshake on the same cycle wins.
//  - Unused state encodings -> FETCH with all outputs 0.
// STRUCTURE
//  - ctrl_pkg: state localparams, opcode constants, ALUOp encodings (ALU_ADD=00, ALU_R=01, ALU_PASS=10, ALU_CMP=11).
//  - Sub-module irq_prio_enc (NUM_IRQ in -> valid, lowest-index id); everything else stays in this file.
// TESTING
//  - ADDI: gnt cycle 1, r_valid cycle 2 with opcode 0010011 -> EXEC write_enable=1 ALUOp=00 Mux2=1; WB pc_enable=1; 4 cycles total.
//  - LH, addr_lo=2'b10, data_gnt delayed 3 cycles -> data_req held 3 cycles with data_be=1100; r_valid -> write_enable+alu_dm_select.
//  - SW, addr_lo=2'b01 -> misalign=1, data_req never set, TRAP, pc_enable=1, back in FETCH.
//  - irq=4'b1010 in FETCH, irq_status=0 -> IRQ_ENTRY irq_id=1, then irq_ack=0010 for 1 cycle; irq mid-FWAIT is ignored until next FETCH.
//  - TIMEOUT=16, instr_r_valid never arrives -> bus_err on cycle 16 of FWAIT, TRAP, FETCH; RES mid-MEM_REQ -> next cycle all outputs 0.
//  - opcode 0001111 -> illegal_instr=1 and pc_enable=1 for 1 cycle, no write_enable; MRET -> mret_sel, irq_status_update, irq_context=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, RV32 opcode constants and ALU operation codes
// for the ctrl_seq_v2 control sequencer.
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_FWAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_IRQ_ENTRY, S_IRQ_ACK, S_TRAP
    } state_e;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_R    = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_CMP  = 2'b11;
    // Opcodes that write rd straight from the ALU and then retire through WB.
    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_JAL, OP_JALR};
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: reports whether any request is set and the index of the lowest one.
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] id_o
);
    always_comb begin
        valid_o = |req_i;
        id_o = '0;
        for (int i = N - 1; i >= 0; i--) if (req_i[i]) id_o = W'(i);
    end
endmodule

// File: rtl/ctrl_seq_v2.sv
// ctrl_seq_v2: multi-cycle RV32 control sequencer with prioritised interrupts,
// byte/half/word strobes, misalign trap and bus timeout.
module ctrl_seq_v2 import ctrl_pkg::*; #(
    parameter int                 NUM_IRQ  = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_MASK = {NUM_IRQ{1'b1}},
    parameter int                 TIMEOUT  = 16,
    parameter int                 IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr_lo,
    output logic                instr_req,
    input  logic                instr_gnt,
    input  logic                instr_r_valid,
    output logic                data_req,
    output logic                data_write_enable,
    output logic [3:0]          data_be,
    input  logic                data_gnt,
    input  logic                data_r_valid,
    output logic                pc_enable,
    output logic                MODE,
    output logic                reg_pc_select,
    output logic                write_enable,
    output logic                ALUSrcMux1,
    output logic                ALUSrcMux2,
    output logic                ALUSrcMux1_S,
    output logic                ALUSrcMux2_S,
    output logic [1:0]          ALUOp,
    output logic                alu_dm_select,
    output logic                instr_reg_mux,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_status,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic                irq_status_update,
    output logic                irq_context,
    output logic                irq_addr_sel,
    output logic                bckup_reg,
    output logic                mret_sel,
    output logic                illegal_instr,
    output logic                bus_err,
    output logic                misalign
);
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
    state_e state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [2:0] f3_q, f3_d;
    logic [IRQ_ID_W-1:0] id_q, id_d, pend_id;
    logic [15:0] timer_q;
    logic pend_any, pend, count, expired, mis, is_load, f3_unused;
    logic [3:0] be;
    irq_prio_enc #(.N(NUM_IRQ), .W(IRQ_ID_W)) u_enc (
        .req_i(irq & IRQ_MASK), .valid_o(pend_any), .id_o(pend_id)
    );
    assign pend = pend_any && !irq_status;
    assign expired = (TIMEOUT != 0) && (timer_q == TLAST);
    assign is_load = op_q == OP_LOAD;
    assign f3_unused = f3_q[2];
    assign be = (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_lo :
                (f3_q[1:0] == 2'b01) ? 4'b0011 << {addr_lo[1], 1'b0} :
                (f3_q[1:0] == 2'b10) ? 4'b1111 : 4'b0000;
    assign mis = (f3_q[1:0] == 2'b01 && addr_lo[0]) || (f3_q[1:0] == 2'b10 && addr_lo != 2'b00) ||
                 f3_q[1:0] == 2'b11;
    always_comb begin
        state_d = state_q; op_d = op_q; f3_d = f3_q; id_d = id_q; count = 1'b0;
        instr_req = 1'b0; data_req = 1'b0; data_write_enable = 1'b0; data_be = 4'b0000;
        pc_enable = 1'b0; MODE = 1'b0; reg_pc_select = 1'b0; write_enable = 1'b0;
        ALUSrcMux1 = 1'b0; ALUSrcMux2 = 1'b0; ALUSrcMux1_S = 1'b0; ALUSrcMux2_S = 1'b0;
        ALUOp = ALU_ADD; alu_dm_select = 1'b0; instr_reg_mux = 1'b0;
        irq_ack = '0; irq_id = '0; irq_status_update = 1'b0; irq_context = 1'b0;
        irq_addr_sel = 1'b0; bckup_reg = 1'b0; mret_sel = 1'b0;
        illegal_instr = 1'b0; bus_err = 1'b0; misalign = 1'b0;
        if (!RES) begin
            // Datapath steering is a pure function of the opcode while it is in flight.
            if (state_q inside {S_EXEC, S_MEM_REQ, S_WB}) begin
                case (op_q)
                    OP_LUI:    begin ALUOp = ALU_PASS; ALUSrcMux2 = 1'b1; ALUSrcMux1_S = 1'b1; end
                    OP_AUIPC:  begin ALUOp = ALU_PASS; ALUSrcMux1 = 1'b1; ALUSrcMux2 = 1'b1; end
                    OP_OPIMM:  begin ALUOp = ALU_ADD; ALUSrcMux2 = 1'b1; end
                    OP_OP:     ALUOp = ALU_R;
                    OP_JAL:    begin ALUOp = ALU_CMP; ALUSrcMux1 = 1'b1; ALUSrcMux2_S = 1'b1; MODE = 1'b1; end
                    OP_JALR:   begin
                        ALUOp = ALU_PASS; ALUSrcMux1 = 1'b1; ALUSrcMux2_S = 1'b1; MODE = 1'b1; reg_pc_select = 1'b1;
                    end
                    OP_BRANCH: begin ALUOp = ALU_CMP; MODE = 1'b1; end
                    OP_LOAD:   begin ALUOp = ALU_ADD; ALUSrcMux2 = 1'b1; end
                    OP_STORE:  begin ALUOp = ALU_R; ALUSrcMux2 = 1'b1; end
                    default:   ;
                endcase
            end
            case (state_q)
                S_FETCH: begin
                    if (pend) begin
                        state_d = S_IRQ_ENTRY; id_d = pend_id;
                    end else begin
                        instr_req = 1'b1; count = 1'b1;
                        if (instr_gnt) state_d = S_FWAIT;
                        else if (expired) begin bus_err = 1'b1; state_d = S_TRAP; end
                    end
                end
                S_FWAIT: begin
                    count = 1'b1;
                    if (instr_r_valid) begin state_d = S_EXEC; op_d = opcode; f3_d = funct3; end
                    else if (expired) begin bus_err = 1'b1; state_d = S_TRAP; end
                end
                S_EXEC: begin
                    if (writes_rd(op_q)) begin
                        write_enable = 1'b1; state_d = S_WB;
                    end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                        state_d = S_MEM_REQ;
                    end else begin
                        pc_enable = 1'b1; state_d = S_FETCH;
                        MODE = MODE || op_q == OP_SYSTEM;
                        mret_sel = op_q == OP_SYSTEM;
                        irq_status_update = op_q == OP_SYSTEM;
                        illegal_instr = !(op_q inside {OP_BRANCH, OP_SYSTEM});
                    end
                end
                S_MEM_REQ: begin
                    data_write_enable = op_q == OP_STORE;
                    if (mis) begin
                        misalign = 1'b1; state_d = S_TRAP;
                    end else begin
                        data_req = 1'b1; data_be = be; count = 1'b1;
                        if (data_gnt) state_d = S_MEM_WAIT;
                        else if (expired) begin bus_err = 1'b1; state_d = S_TRAP; end
                    end
                end
                S_MEM_WAIT: begin
                    count = 1'b1; instr_reg_mux = is_load;
                    if (data_r_valid) begin
                        write_enable = is_load; alu_dm_select = is_load; state_d = S_WB;
                    end else if (expired) begin
                        bus_err = 1'b1; state_d = S_TRAP;
                    end
                end
                S_WB: begin pc_enable = 1'b1; state_d = S_FETCH; end
                S_IRQ_ENTRY: begin
                    pc_enable = 1'b1; MODE = 1'b1; bckup_reg = 1'b1; irq_addr_sel = 1'b1;
                    irq_status_update = 1'b1; irq_context = 1'b1; irq_id = id_q; state_d = S_IRQ_ACK;
                end
                S_IRQ_ACK: begin irq_ack = NUM_IRQ'(1) << id_q; irq_id = id_q; state_d = S_FETCH; end
                S_TRAP: begin pc_enable = 1'b1; state_d = S_FETCH; end
                default: state_d = S_FETCH;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= S_FETCH; op_q <= '0; f3_q <= '0; id_q <= '0; timer_q <= '0;
        end else begin
            state_q <= state_d; op_q <= op_d; f3_q <= f3_d; id_q <= id_d;
            timer_q <= (state_d != state_q) ? 16'd0 : timer_q + 16'(count);
        end
    end
endmodule
